// File: rtl/writeback_regfile.sv
// writeback_regfile: WB-stage write-back mux, 2R1W register file with write-first bypass,
// and a running count of committed register writes.
module writeback_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              regWrite_in,
  input  logic              NoWrite_in,
  input  logic              MemRead_in,
  input  logic              stall_in,
  input  logic [4:0]        writeReg_in,
  input  logic [DATA_W-1:0] dataMem_in,
  input  logic [DATA_W-1:0] ALUoutput_in,
  input  logic [4:0]        readReg1_in,
  input  logic [4:0]        readReg2_in,
  output logic [DATA_W-1:0] readData1_out,
  output logic [DATA_W-1:0] readData2_out,
  output logic [DATA_W-1:0] writeData_out,
  output logic              writeEn_out,
  output logic [31:0]       commitCount_out
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [31:0]       commit_q, commit_d;
  logic [DATA_W-1:0] wdata;
  logic              we;
  always_comb begin
    we       = regWrite_in & ~NoWrite_in & ~stall_in & (writeReg_in != 5'd0) & ~Rst;
    wdata    = we ? (MemRead_in ? dataMem_in : ALUoutput_in) : (MemRead_in ? dataMem_in : ALUoutput_in);
    commit_d = commit_q + 32'(we);
  end
  // Same-cycle bypass makes the ID read see the value being written back (write-first).
  always_comb begin
    readData1_out = (we && readReg1_in == writeReg_in) ? wdata :
                    (readReg1_in == 5'd0 || 32'(readReg1_in) >= NUM_REGS) ? '0 : regs_q[readReg1_in];
    readData2_out = (we && readReg2_in == writeReg_in) ? wdata :
                    (readReg2_in == 5'd0 || 32'(readReg2_in) >= NUM_REGS) ? '0 : regs_q[readReg2_in];
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      commit_q <= '0;
    end else begin
      if (we && 32'(writeReg_in) < NUM_REGS) regs_q[writeReg_in] <= wdata;
      commit_q <= commit_d;
    end
  end
  assign writeData_out   = wdata;
  assign writeEn_out     = we;
  assign commitCount_out = commit_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: randomized plus directed stimulus against an array-based reference
// model; expectations are queued by the driver and checked by an independent monitor.
module tb_writeback_regfile;
  logic        Clk = 1'b0;
  logic        Rst, regWrite_in, NoWrite_in, MemRead_in, stall_in;
  logic [4:0]  writeReg_in, readReg1_in, readReg2_in;
  logic [31:0] dataMem_in, ALUoutput_in;
  logic [31:0] readData1_out, readData2_out, writeData_out, commitCount_out;
  logic        writeEn_out;

  writeback_regfile dut (
    .Clk(Clk), .Rst(Rst), .regWrite_in(regWrite_in), .NoWrite_in(NoWrite_in),
    .MemRead_in(MemRead_in), .stall_in(stall_in), .writeReg_in(writeReg_in),
    .dataMem_in(dataMem_in), .ALUoutput_in(ALUoutput_in), .readReg1_in(readReg1_in),
    .readReg2_in(readReg2_in), .readData1_out(readData1_out), .readData2_out(readData2_out),
    .writeData_out(writeData_out), .writeEn_out(writeEn_out), .commitCount_out(commitCount_out)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] rd1, rd2, wd, cnt;
    logic        we;
  } exp_t;

  exp_t        q[$];
  bit   [31:0] mem [32];
  bit   [31:0] cnt;
  int          checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the edge, queue what the outputs must be, then advance the model.
  task automatic cyc(input bit rst, input bit rw, input bit nw, input bit mr, input bit st,
                     input logic [4:0] wr, input logic [31:0] dm, input logic [31:0] alu,
                     input logic [4:0] r1, input logic [4:0] r2, input bit push = 1'b1);
    exp_t e;
    @(posedge Clk);
    #1;
    Rst = rst; regWrite_in = rw; NoWrite_in = nw; MemRead_in = mr; stall_in = st;
    writeReg_in = wr; dataMem_in = dm; ALUoutput_in = alu; readReg1_in = r1; readReg2_in = r2;
    e.wd  = mr ? dm : alu;
    e.we  = rw && !nw && !st && wr != 0 && !rst;
    e.rd1 = (e.we && r1 == wr) ? e.wd : mem[r1];
    e.rd2 = (e.we && r2 == wr) ? e.wd : mem[r2];
    e.cnt = cnt;
    if (push) q.push_back(e);
    if (rst) begin
      foreach (mem[i]) mem[i] = 0;
      cnt = 0;
    end else if (e.we) begin
      mem[wr] = e.wd;
      cnt++;
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    cyc(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, r1, r2);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("writeEn", {31'b0, writeEn_out}, {31'b0, e.we});
        chk("writeData", writeData_out, e.wd);
        chk("readData1", readData1_out, e.rd1);
        chk("readData2", readData2_out, e.rd2);
        chk("commitCount", commitCount_out, e.cnt);
      end
    end
  end

  initial begin : driver
    int n;
    Rst = 1; regWrite_in = 0; NoWrite_in = 0; MemRead_in = 0; stall_in = 0;
    writeReg_in = 0; dataMem_in = 0; ALUoutput_in = 0; readReg1_in = 0; readReg2_in = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd31);
    idle(5'd17, 5'd2);
    cyc(0, 1, 0, 0, 0, 5'd5, 32'h0, 32'h0000_00AA, 5'd5, 5'd0);
    idle(5'd5, 5'd5);
    cyc(0, 1, 0, 1, 0, 5'd7, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd7);
    idle(5'd7, 5'd7);
    cyc(0, 1, 0, 0, 1, 5'd5, 32'h0, 32'h1234, 5'd5, 5'd0);
    cyc(0, 1, 1, 0, 0, 5'd5, 32'h0, 32'h1234, 5'd5, 5'd0);
    cyc(0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h1234, 5'd0, 5'd5);
    idle(5'd5, 5'd0);
    cyc(1, 1, 0, 0, 0, 5'd3, 32'h0, 32'h55, 5'd3, 5'd3);
    idle(5'd3, 5'd5);
    cyc(0, 1, 0, 0, 0, 5'd3, 32'h0, 32'h66, 5'd1, 5'd3);
    idle(5'd3, 5'd0);
    cyc(0, 1, 0, 0, 0, 5'd9, 32'h0, 32'h1, 5'd9, 5'd0);
    cyc(0, 1, 0, 0, 0, 5'd9, 32'h0, 32'h2, 5'd9, 5'd9);
    idle(5'd9, 5'd9);
    // Counter wrap via backdoor preload during an idle cycle.
    idle(5'd0, 5'd0);
    @(posedge Clk);
    #1;
    force dut.commit_q = 32'hFFFF_FFFF;
    #1;
    release dut.commit_q;
    cnt = 32'hFFFF_FFFF;
    cyc(0, 1, 0, 0, 0, 5'd4, 32'h0, 32'hCAFE_0004, 5'd4, 5'd0);
    idle(5'd4, 5'd0);
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wr, r1, r2;
      wr = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, wr, $urandom, $urandom, r1, r2);
    end
    idle(5'd0, 5'd0);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge Clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter DATA_W, default 32: width of every data path and register.
REQ-002 Parameter NUM_REGS, default 32: number of architectural registers, addressed by 5 bits.
REQ-003 Clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Rst  input  1: synchronous, active-high reset, sampled on rising Clk.
REQ-005 regWrite_in  input  1: write-back request from the MEM/WB stage.
REQ-006 NoWrite_in  input  1: suppresses the write-back when 1, e.g. a conditional move that is not taken.
REQ-007 MemRead_in  input  1: selects the write-back source; 1 = dataMem_in, 0 = ALUoutput_in.
REQ-008 stall_in  input  1: bubble marker; when 1, the instruction in WB is a bubble.
REQ-009 writeReg_in  input  5: destination register index.
REQ-010 dataMem_in  input  DATA_W: load data from the MEM/WB buffer.
REQ-011 ALUoutput_in  input  DATA_W: ALU result from the MEM/WB buffer.
REQ-012 readReg1_in, readReg2_in  input  5 each: ID-stage read addresses.
REQ-013 readData1_out, readData2_out  output  DATA_W each: ID-stage read data, combinational.
REQ-014 writeData_out  output  DATA_W: the selected write-back value, combinational; used by the forwarding logic.
REQ-015 writeEn_out  output  1: the qualified write enable, combinational.
REQ-016 commitCount_out  output  32: registered count of committed register writes.

Function
REQ-017 The write-back value SHALL be defined as wdata = MemRead_in ? dataMem_in : ALUoutput_in.
REQ-018 The qualified write enable SHALL be defined as we = regWrite_in & ~NoWrite_in & ~stall_in & (writeReg_in != 0) & ~Rst.
REQ-019 writeData_out SHALL equal wdata and writeEn_out SHALL equal we in the same cycle, with zero latency.
REQ-020 On a rising Clk with we=1, register[writeReg_in] SHALL take the value wdata; all other registers SHALL hold.
REQ-021 Register 0 SHALL always read as 0; a write to index 0 SHALL be discarded and SHALL NOT increment commitCount_out.
REQ-022 Reads SHALL be asynchronous: readDataN_out = register[readRegN_in], with 0 returned for index 0.
REQ-023 Internal bypass: when we=1 and readRegN_in == writeReg_in, readDataN_out SHALL equal wdata in the same cycle, giving write-first behaviour for the same-cycle ID read.
REQ-024 Both read ports SHALL be independent; the same address on both ports SHALL return identical data, with the bypass applied to each port.
REQ-025 commitCount_out SHALL increment by 1 on each rising Clk with we=1.
REQ-026 commitCount_out SHALL wrap from 0xFFFFFFFF to 0x00000000 with no flag.
REQ-027 When stall_in=1, no register SHALL change regardless of regWrite_in; reads SHALL remain valid.
REQ-028 When NoWrite_in=1 and regWrite_in=1, no write SHALL occur and no bypass SHALL be applied.
REQ-029 Back-to-back writes to the same register on consecutive cycles SHALL each take effect; a read after the second write SHALL return the second value.
REQ-030 An X on MemRead_in while we=0 SHALL NOT corrupt state.

Reset
REQ-031 On a rising Clk with Rst=1, all NUM_REGS registers SHALL be cleared to 0 and commitCount_out SHALL be cleared to 0.
REQ-032 Rst SHALL take priority over a simultaneous write: the write SHALL be dropped and no bypass SHALL be applied while Rst=1.
REQ-033 Reset asserted mid-stream SHALL discard the in-flight write; the first post-reset write SHALL produce commitCount_out=1.
REQ-034 After reset, readData1_out and readData2_out SHALL read 0 for every address until written.

Verification
REQ-035 Write select: Rst pulse, then regWrite_in=1, MemRead_in=0, ALUoutput_in=0x0000_00AA, writeReg_in=5 for 1 cycle; readReg1_in=5 -> readData1_out=0x0000_00AA, commitCount_out=1.
REQ-036 Load path and bypass: MemRead_in=1, dataMem_in=0xDEAD_BEEF, writeReg_in=7, readReg2_in=7 in the same cycle -> readData2_out=0xDEAD_BEEF before the edge; the value is retained after the edge.
REQ-037 Suppression: 1 cycle each with (stall_in=1), (NoWrite_in=1), and (writeReg_in=0), each with ALUoutput_in=0x1234 and regWrite_in=1 -> target register unchanged, register 0 reads 0, commitCount_out unchanged.
REQ-038 Reset priority: Rst=1 together with a valid write of 0x55 to r3 -> after the edge, r3=0 and commitCount_out=0; the next write then gives commitCount_out=1.
REQ-039 Consecutive writes: r9 <= 0x1 on cycle N, then r9 <= 0x2 on cycle N+1 -> r9 reads 0x2 and commitCount_out advances by 2.
REQ-040 Wrap: force commitCount_out to 0xFFFFFFFF through 2^32-1 writes (or a backdoor preload), then one further write -> commitCount_out=0.
